// File: rtl/exec_cycle_controller_if.sv
// Memory handshake bundle between the cycle controller and the memory.
//   mem_req     : access request (controller -> memory)
//   mem_we      : write strobe for the current access
//   iord        : address select, 0 = pc, 1 = ALU result
//   instr_rdata : read data returned by memory
//   mem_ready   : memory acknowledge for the current access
interface exec_cycle_controller_if;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic [31:0] instr_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, iord, input instr_rdata, mem_ready);
   modport slave  (input mem_req, mem_we, iord, output instr_rdata, mem_ready);
endinterface

// File: rtl/exec_cycle_controller.sv
// Multi-cycle instruction sequencer for a MIPS subset (R add/sub/and/or/slt,
// lw, sw, addi, beq). Steps each instruction through FETCH, DECODE, EXECUTE,
// MEM and WRITEBACK, owns pc and ir, and drives ALU / memory / register-file
// controls. Memory accesses wait on mem_ready with a bounded wait-state count.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start, stop     : begin from IDLE / return to IDLE at instruction completion
//   alu_zero        : ALU zero flag for beq
//   mem             : memory handshake interface (master side)
//   pc, ir, state   : architectural registers and current FSM state
//   alu_op, alu_src_imm, reg_write, reg_dst, mem_to_reg : datapath controls
//   busy, fault, instr_done, instr_count                 : status
module exec_cycle_controller #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          MAX_WAIT = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    alu_zero,
   exec_cycle_controller_if.master mem,
   output logic [31:0]             pc,
   output logic [31:0]             ir,
   output logic [2:0]              state,
   output logic [2:0]              alu_op,
   output logic                    alu_src_imm,
   output logic                    reg_write,
   output logic                    reg_dst,
   output logic                    mem_to_reg,
   output logic                    busy,
   output logic                    fault,
   output logic                    instr_done,
   output logic [15:0]             instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Last wait count value that is still allowed; one more low cycle faults.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      cur, nxt;
   logic [7:0]  wait_cnt;
   logic        complete;
   logic        waiting;

   logic [5:0]  opcode, funct;
   logic        is_r, is_lw, is_sw, is_addi, is_beq, legal;
   logic [2:0]  r_op;
   logic        r_ok;

   assign opcode  = ir[31:26];
   assign funct   = ir[5:0];
   assign is_r    = (opcode == 6'b000000);
   assign is_lw   = (opcode == 6'b100011);
   assign is_sw   = (opcode == 6'b101011);
   assign is_addi = (opcode == 6'b001000);
   assign is_beq  = (opcode == 6'b000100);

   always_comb begin
      r_op = ALU_ADD;
      r_ok = 1'b1;
      case (funct)
         6'b100000: r_op = ALU_ADD;
         6'b100010: r_op = ALU_SUB;
         6'b100100: r_op = ALU_AND;
         6'b100101: r_op = ALU_OR;
         6'b101010: r_op = ALU_SLT;
         default:   r_ok = 1'b0;
      endcase
   end

   assign legal = (is_r & r_ok) | is_lw | is_sw | is_addi | is_beq;

   // Next state and controls. Controls depend only on cur and ir; inputs
   // only steer nxt and the register updates.
   always_comb begin
      nxt         = cur;
      complete    = 1'b0;
      waiting     = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      mem.iord    = 1'b0;
      alu_op      = 3'b000;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      fault       = 1'b0;
      case (cur)
         S_IDLE: if (start) nxt = S_FETCH;
         S_FETCH: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready)            nxt = S_DECODE;
            else if (wait_cnt == WAIT_LAST) nxt = S_FAULT;
            else                          waiting = 1'b1;
         end
         S_DECODE: nxt = legal ? S_EXEC : S_FAULT;
         S_EXEC: begin
            if (is_r) begin
               alu_op = r_op;
               nxt    = S_WB;
            end else if (is_beq) begin
               alu_op   = ALU_SUB;
               complete = 1'b1;
            end else begin
               alu_op      = ALU_ADD;
               alu_src_imm = 1'b1;
               nxt         = is_addi ? S_WB : S_MEM;
            end
         end
         S_MEM: begin
            mem.mem_req = 1'b1;
            mem.iord    = 1'b1;
            mem.mem_we  = is_sw;
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            if (mem.mem_ready) begin
               if (is_sw) complete = 1'b1;
               else       nxt      = S_WB;
            end else if (wait_cnt == WAIT_LAST) begin
               nxt = S_FAULT;
            end else begin
               waiting = 1'b1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_r;
            mem_to_reg = is_lw;
            complete   = 1'b1;
         end
         S_FAULT: fault = 1'b1;
         default: nxt = S_FAULT;
      endcase
      if (complete) nxt = stop ? S_IDLE : S_FETCH;
   end

   assign state = cur;
   assign busy  = (cur != S_IDLE) && (cur != S_FAULT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= S_IDLE;
         pc          <= PC_RESET;
         ir          <= '0;
         wait_cnt    <= '0;
         instr_count <= '0;
         instr_done  <= 1'b0;
      end else begin
         cur        <= nxt;
         instr_done <= complete;
         // Counter only runs while stalled; any other cycle (including
         // entry to FETCH/MEM and a ready) leaves it at zero.
         wait_cnt   <= waiting ? wait_cnt + 8'd1 : 8'd0;
         if (complete) instr_count <= instr_count + 16'd1;
         if (cur == S_FETCH && mem.mem_ready) begin
            ir <= mem.instr_rdata;
            pc <= pc + 32'd4;
         end
         // pc already points past the branch here.
         if (cur == S_EXEC && is_beq && alu_zero)
            pc <= pc + {{14{ir[15]}}, ir[15:0], 2'b00};
      end
   end

endmodule

// File: tb/tb_exec_cycle_controller.sv
// Directed bench for exec_cycle_controller: reset, each instruction class,
// wait states, timeout, illegal decode and asynchronous reset mid-access.
module tb_exec_cycle_controller;
   logic        clk = 1'b0;
   logic        reset, start, stop, alu_zero;
   logic [31:0] pc, ir;
   logic [2:0]  state, alu_op;
   logic        alu_src_imm, reg_write, reg_dst, mem_to_reg;
   logic        busy, fault, instr_done;
   logic [15:0] instr_count;
   int          ncmp = 0;
   int          nerr = 0;

   exec_cycle_controller_if bus ();

   exec_cycle_controller #(.PC_RESET(32'h0), .MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .alu_zero(alu_zero),
      .mem(bus), .pc(pc), .ir(ir), .state(state), .alu_op(alu_op),
      .alu_src_imm(alu_src_imm), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .busy(busy), .fault(fault),
      .instr_done(instr_done), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; start = 1'b0; stop = 1'b1; alu_zero = 1'b0;
      bus.mem_ready = 1'b1; bus.instr_rdata = 32'h0;
      tick;
      reset = 1'b1;
      tick;
   endtask

   // start, fetch with zero wait states, leave the DUT in DECODE
   task automatic start_fetch(input logic [31:0] instr);
      bus.instr_rdata = instr;
      bus.mem_ready   = 1'b1;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("fetch state", 32'(state), 32'd1);
      chk("fetch req", 32'(bus.mem_req), 32'd1);
      chk("fetch iord", 32'(bus.iord), 32'd0);
      tick;
      chk("decode state", 32'(state), 32'd2);
      chk("decode ir", ir, instr);
   endtask

   // R-type / addi table: instruction, alu_op, alu_src_imm, reg_dst
   logic [31:0] tv_instr [6] = '{32'h00430820, 32'h00430822, 32'h00430824,
                                 32'h00430825, 32'h0043082A, 32'h20410005};
   logic [2:0]  tv_op    [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
   logic        tv_imm   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        tv_dst   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset values
      reset = 1'b0; start = 1'b0; stop = 1'b1; alu_zero = 1'b0;
      bus.mem_ready = 1'b1; bus.instr_rdata = 32'h0;
      tick;
      chk("rst state", 32'(state), 32'd0);
      chk("rst pc", pc, 32'h0);
      chk("rst ir", ir, 32'h0);
      chk("rst count", 32'(instr_count), 32'd0);
      chk("rst req", 32'(bus.mem_req), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick;

      // lw, zero wait states
      start_fetch(32'h8C220004);
      chk("lw pc", pc, 32'h4);
      tick;
      chk("lw ex state", 32'(state), 32'd3);
      chk("lw ex aluop", 32'(alu_op), 32'd2);
      chk("lw ex imm", 32'(alu_src_imm), 32'd1);
      chk("lw ex rw", 32'(reg_write), 32'd0);
      tick;
      chk("lw mem state", 32'(state), 32'd4);
      chk("lw mem req", 32'(bus.mem_req), 32'd1);
      chk("lw mem iord", 32'(bus.iord), 32'd1);
      chk("lw mem we", 32'(bus.mem_we), 32'd0);
      chk("lw mem rw", 32'(reg_write), 32'd0);
      tick;
      chk("lw wb state", 32'(state), 32'd5);
      chk("lw wb rw", 32'(reg_write), 32'd1);
      chk("lw wb m2r", 32'(mem_to_reg), 32'd1);
      chk("lw wb dst", 32'(reg_dst), 32'd0);
      chk("lw wb done", 32'(instr_done), 32'd0);
      tick;
      chk("lw idle", 32'(state), 32'd0);
      chk("lw done", 32'(instr_done), 32'd1);
      chk("lw count", 32'(instr_count), 32'd1);
      chk("lw rw off", 32'(reg_write), 32'd0);
      tick;
      chk("lw done pulse", 32'(instr_done), 32'd0);

      // fetch timeout: ir and pc keep the lw values
      bus.mem_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("to fetch", 32'(state), 32'd1);
      n = 0;
      while (state != 3'd7 && n < 40) begin
         tick;
         n++;
      end
      chk("to cycles", 32'(n), 32'd15);
      chk("to ir", ir, 32'h8C220004);
      chk("to pc", pc, 32'h4);
      chk("to fault", 32'(fault), 32'd1);
      chk("to busy", 32'(busy), 32'd0);
      chk("to req", 32'(bus.mem_req), 32'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("to sticky", 32'(state), 32'd7);

      // sw with three wait states in MEM
      do_reset;
      start_fetch(32'hAC220008);
      bus.mem_ready = 1'b0;
      tick;
      chk("sw ex state", 32'(state), 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("sw mem state", 32'(state), 32'd4);
         chk("sw mem we", 32'(bus.mem_we), 32'd1);
         if (i == 3) bus.mem_ready = 1'b1;
      end
      tick;
      chk("sw idle", 32'(state), 32'd0);
      chk("sw we off", 32'(bus.mem_we), 32'd0);
      chk("sw fault", 32'(fault), 32'd0);
      chk("sw pc", pc, 32'h4);
      chk("sw done", 32'(instr_done), 32'd1);

      // asynchronous reset in the middle of a sw MEM cycle
      do_reset;
      start_fetch(32'hAC220008);
      bus.mem_ready = 1'b0;
      tick;
      tick;
      chk("ar mem we", 32'(bus.mem_we), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar req", 32'(bus.mem_req), 32'd0);
      chk("ar we", 32'(bus.mem_we), 32'd0);
      chk("ar state", 32'(state), 32'd0);
      chk("ar pc", pc, 32'h0);
      chk("ar count", 32'(instr_count), 32'd0);

      // beq taken
      do_reset;
      alu_zero = 1'b1;
      start_fetch(32'h10000003);
      tick;
      chk("beq ex state", 32'(state), 32'd3);
      chk("beq aluop", 32'(alu_op), 32'd6);
      chk("beq imm", 32'(alu_src_imm), 32'd0);
      tick;
      chk("beq t pc", pc, 32'h10);
      chk("beq t state", 32'(state), 32'd0);
      chk("beq t count", 32'(instr_count), 32'd1);

      // beq not taken, stop=0 continues to FETCH
      do_reset;
      alu_zero = 1'b0;
      stop = 1'b0;
      start_fetch(32'h10000003);
      tick;
      tick;
      chk("beq nt pc", pc, 32'h4);
      chk("beq nt next", 32'(state), 32'd1);
      stop = 1'b1;

      // R-type and addi
      for (int k = 0; k < 6; k++) begin
         do_reset;
         start_fetch(tv_instr[k]);
         tick;
         chk("rt aluop", 32'(alu_op), 32'(tv_op[k]));
         chk("rt imm", 32'(alu_src_imm), 32'(tv_imm[k]));
         tick;
         chk("rt wb state", 32'(state), 32'd5);
         chk("rt wb rw", 32'(reg_write), 32'd1);
         chk("rt wb dst", 32'(reg_dst), 32'(tv_dst[k]));
         chk("rt wb m2r", 32'(mem_to_reg), 32'd0);
         tick;
         chk("rt idle", 32'(state), 32'd0);
      end

      // illegal opcode and illegal funct
      do_reset;
      start_fetch(32'hFC000000);
      tick;
      chk("ill op state", 32'(state), 32'd7);
      chk("ill op fault", 32'(fault), 32'd1);
      chk("ill op busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("ill op sticky", 32'(state), 32'd7);
      do_reset;
      start_fetch(32'h00000000);
      tick;
      chk("ill fn state", 32'(state), 32'd7);
      chk("ill fn fault", 32'(fault), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/exec_cycle_controller.md
Name: exec_cycle_controller

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the ALU, Memory and RegisterFile control inputs and owns the PC and the instruction register. Memory accesses use a req/ready handshake with a wait-state timeout. It supports MIPS-subset R-type (add/sub/and/or/slt), lw, sw, addi and beq.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, maximum consecutive cycles with mem_ready low in FETCH/MEM before FAULT (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  in IDLE, begin fetching at current pc
stop  input  1  sampled at instruction completion; 1 returns to IDLE
instr_rdata  input  32  memory read data, captured into ir in FETCH
mem_ready  input  1  memory handshake acknowledge
alu_zero  input  1  ALU zero flag, used by beq
pc  output  32  program counter
ir  output  32  instruction register
state  output  3  IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WRITEBACK=5 FAULT=7
mem_req  output  1  memory access request
mem_we  output  1  memory write (MemWrite)
iord  output  1  0 = address from pc, 1 = address from ALU_result
alu_op  output  3  AND=000 OR=001 ADD=010 SUB=110 SLT=111
alu_src_imm  output  1  ALU B operand = sign-extended imm[15:0]
reg_write  output  1  register file write enable
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  write-back source is memory
busy  output  1  state not IDLE and not FAULT
fault  output  1  sticky illegal-instruction or timeout flag
instr_done  output  1  one-cycle retirement pulse
instr_count  output  16  retired-instruction counter, wraps

Behaviour:
- Reset (async, reset=0): state=IDLE, pc=PC_RESET, ir=0, instr_count=0, wait counter=0, instr_done=0. All control outputs are 0 immediately, including a mem_req that was in flight.
- Control outputs are decoded only from the registered state and ir. No input reaches them combinationally.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1, iord=0, mem_we=0.
  - On mem_ready=1: ir<=instr_rdata, pc<=pc+4 (mod 2^32), -> DECODE.
- DECODE: one cycle.
  - Legal: opcode 000000 with funct in {100000, 100010, 100100, 100101, 101010}; opcodes 100011, 101011, 001000, 000100.
  - Anything else -> FAULT. Legal -> EXECUTE.
- EXECUTE:
  - R-type: alu_op from funct, -> WRITEBACK.
  - lw, sw, addi: alu_op=ADD, alu_src_imm=1. lw/sw -> MEM, addi -> WRITEBACK.
  - beq: alu_op=SUB, alu_src_imm=0. If alu_zero=1, pc<=pc+(sext(imm)<<2), using the already-incremented pc. Instruction completes.
- MEM: mem_req=1, iord=1, alu_op=ADD, alu_src_imm=1, mem_we=1 for sw only.
  - On mem_ready: sw completes, lw -> WRITEBACK.
- WRITEBACK: reg_write=1 for exactly one cycle.
  - reg_dst=1 for R-type.
  - mem_to_reg=1 for lw.
  - Instruction completes.
- Completion:
  - instr_count increments.
  - instr_done=1 in the following cycle, for one cycle only.
  - Next state is IDLE if stop=1, else FETCH.
- Latency with zero wait states, counted from FETCH entry to completion state inclusive: lw 5, sw 4, R/addi 4, beq 3.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on ready.
  - Increments each cycle mem_ready=0.
  - MAX_WAIT consecutive low cycles -> FAULT with no ir/pc update.
  - mem_ready is ignored outside FETCH/MEM.
- FAULT: fault=1, all other controls 0. Exited only by reset; start is ignored.
- instr_count wraps from 16'hFFFF to 0.
- start while busy is ignored. stop outside a completion cycle is ignored.

Test Plan:
- Reset mid-MEM of sw with reset=0 -> mem_req and mem_we drop asynchronously; state=0, pc=PC_RESET, instr_count=0.
- start, instr 32'h8C220004 (lw), mem_ready always 1 -> states 1,2,3,4,5; reg_write=1 with mem_to_reg=1 only in state 5; pc=4; instr_done pulses once; instr_count=1.
- sw 32'hAC220008 with mem_ready delayed 3 cycles in MEM -> mem_we=1 held 4 cycles; no fault; pc=4.
- beq 32'h10000003 at pc=0, alu_zero=1 -> pc=0x10 after EXECUTE. With alu_zero=0 -> pc=4. Both take 3 cycles.
- Opcode 6'b111111 or R-type funct 6'b000000 -> FAULT after DECODE, fault=1; a subsequent start has no effect.
- mem_ready held 0 in FETCH -> FAULT exactly MAX_WAIT cycles after entry; ir unchanged.
